// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared state encoding and constants for the fetch stage
package instruction_fetch_pkg;

   // Fetch FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

   // Default instruction that ends execution
   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   // Instruction loaded into IF/ID as a bubble
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // Byte distance between consecutive instructions
   localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-addressed instruction store, sync write, comb read
module instruction_memory
   import instruction_fetch_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 10
) (
   input  logic               clock,
   input  logic               write_en,
   input  logic [NB_ADDR-1:0] write_addr,
   input  logic [NB_DATA-1:0] write_data,
   input  logic [NB_ADDR-1:0] read_addr,
   output logic [NB_DATA-1:0] read_data
);

   logic [NB_DATA-1:0] mem [0:(1<<NB_ADDR)-1];

   // Program load port; contents are deliberately not reset
   always_ff @(posedge clock) begin
      if (write_en) begin
         mem[write_addr] <= write_data;
      end
   end

   assign read_data = mem[read_addr];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage with PC, IF/ID register and halt detection (optional STEP_MODE_EN)
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                 NB_DATA   = 32,
   parameter int                 NB_ADDR   = 10,
   parameter logic [NB_DATA-1:0] HALT_WORD = NB_DATA'(HALT_WORD_DEFAULT)
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_stall,
   input  logic               i_flush,
   input  logic               i_redirect,
   input  logic [NB_DATA-1:0] i_redirect_pc,
   input  logic               i_step,
   input  logic               i_imem_we,
   input  logic [NB_ADDR-1:0] i_imem_waddr,
   input  logic [NB_DATA-1:0] i_imem_wdata,
   output logic [NB_DATA-1:0] o_instruction,
   output logic [NB_DATA-1:0] o_pc,
   output logic [NB_DATA-1:0] o_pc_plus4,
   output logic               o_valid,
   output logic               o_halted,
   output logic [NB_DATA-1:0] o_cycle_count
);

   fetch_state_t       state, state_next;
   logic [NB_DATA-1:0] pc, pc_next, pc_incr;
   logic [NB_DATA-1:0] fetch_word, redirect_target;
   logic [NB_DATA-1:0] instr_q, instr_next;
   logic [NB_DATA-1:0] id_pc_q, id_pc_next;
   logic [NB_DATA-1:0] id_pc4_q, id_pc4_next;
   logic [NB_DATA-1:0] cycle_q, cycle_next;
   logic               valid_q, valid_next;
   logic               advance;

   // A non-advancing cycle in RUN behaves like a stall
`ifdef STEP_MODE_EN
   assign advance = i_step;
`else
   logic unused_step;
   assign unused_step = i_step;
   assign advance     = 1'b1;
`endif

   assign pc_incr         = pc + NB_DATA'(PC_INCR);
   assign redirect_target = i_redirect_pc & ~NB_DATA'(3);

   instruction_memory #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR)
   ) u_imem (
      .clock      (i_clock),
      .write_en   (i_imem_we && (state == ST_IDLE)),
      .write_addr (i_imem_waddr),
      .write_data (i_imem_wdata),
      .read_addr  (pc[NB_ADDR+1:2]),
      .read_data  (fetch_word)
   );

   // State, PC, IF/ID and cycle counter registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state    <= ST_IDLE;
         pc       <= '0;
         instr_q  <= NB_DATA'(NOP_WORD);
         id_pc_q  <= '0;
         id_pc4_q <= NB_DATA'(PC_INCR);
         valid_q  <= 1'b0;
         cycle_q  <= '0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         instr_q  <= instr_next;
         id_pc_q  <= id_pc_next;
         id_pc4_q <= id_pc4_next;
         valid_q  <= valid_next;
         cycle_q  <= cycle_next;
      end
   end

   // Next state and IF/ID contents: redirect > stall > flush > normal fetch
   always_comb begin
      state_next  = state;
      pc_next     = pc;
      instr_next  = instr_q;
      id_pc_next  = id_pc_q;
      id_pc4_next = id_pc4_q;
      valid_next  = valid_q;
      cycle_next  = cycle_q;
      case (state)
         ST_IDLE: begin
            instr_next = NB_DATA'(NOP_WORD);
            valid_next = 1'b0;
            if (i_start) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (advance) begin
               cycle_next = cycle_q + NB_DATA'(1);
            end
            if (i_redirect) begin
               pc_next    = redirect_target;
               instr_next = NB_DATA'(NOP_WORD);
               valid_next = 1'b0;
            end else if (advance && !i_stall) begin
               if (i_flush) begin
                  pc_next    = pc_incr;
                  instr_next = NB_DATA'(NOP_WORD);
                  valid_next = 1'b0;
               end else begin
                  instr_next  = fetch_word;
                  id_pc_next  = pc;
                  id_pc4_next = pc_incr;
                  valid_next  = 1'b1;
                  // PC stays on the halt word; it never advances again
                  if (fetch_word == HALT_WORD) begin
                     state_next = ST_HALTED;
                  end else begin
                     pc_next = pc_incr;
                  end
               end
            end
         end
         ST_HALTED: begin
            instr_next = NB_DATA'(NOP_WORD);
            valid_next = 1'b0;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign o_instruction = instr_q;
   assign o_pc          = id_pc_q;
   assign o_pc_plus4    = id_pc4_q;
   assign o_valid       = valid_q;
   assign o_halted      = (state == ST_HALTED);
   assign o_cycle_count = cycle_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

   localparam int          NB_DATA = 32;
   localparam int          NB_ADDR = 10;
   localparam int          DEPTH   = 1 << NB_ADDR;
   localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

   logic               i_clock = 1'b0;
   logic               i_reset, i_start, i_stall, i_flush, i_redirect, i_step, i_imem_we;
   logic [NB_DATA-1:0] i_redirect_pc, i_imem_wdata;
   logic [NB_ADDR-1:0] i_imem_waddr;
   logic [NB_DATA-1:0] o_instruction, o_pc, o_pc_plus4, o_cycle_count;
   logic               o_valid, o_halted;

   instruction_fetch #(
      .NB_DATA   (NB_DATA),
      .NB_ADDR   (NB_ADDR),
      .HALT_WORD (HALT)
   ) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_start       (i_start),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_step        (i_step),
      .i_imem_we     (i_imem_we),
      .i_imem_waddr  (i_imem_waddr),
      .i_imem_wdata  (i_imem_wdata),
      .o_instruction (o_instruction),
      .o_pc          (o_pc),
      .o_pc_plus4    (o_pc_plus4),
      .o_valid       (o_valid),
      .o_halted      (o_halted),
      .o_cycle_count (o_cycle_count)
   );

   // Free-running clock
   always #5 i_clock = ~i_clock;

   int total = 0;
   int bad   = 0;

   // Reference model: program image, run phase and visible IF/ID contents
   logic [31:0] m_mem [DEPTH];
   int          m_phase;   // 0 idle, 1 running, 2 halted
   logic [31:0] m_pc, m_instr, m_opc, m_opc4, m_count;
   logic        m_valid;

   logic [129:0] dut_vec;
   assign dut_vec = {o_instruction, o_pc, o_pc_plus4, o_valid, o_halted, o_cycle_count};

   function automatic logic [129:0] exp_vec();
      return {m_instr, m_opc, m_opc4, m_valid, (m_phase == 2), m_count};
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h1;
      return w;
   endfunction

   // Apply the current inputs to the model, then advance one clock
   task automatic tick();
      logic [31:0] word;
      bit          go;
`ifdef STEP_MODE_EN
      go = i_step;
`else
      go = 1'b1;
`endif
      if (i_reset) begin
         m_phase = 0; m_pc = 0; m_instr = 0; m_opc = 0; m_opc4 = 4; m_valid = 0; m_count = 0;
      end else if (m_phase == 0) begin
         if (i_imem_we) m_mem[i_imem_waddr] = i_imem_wdata;
         m_instr = 0; m_valid = 0;
         if (i_start) m_phase = 1;
      end else if (m_phase == 1) begin
         if (go) m_count = m_count + 1;
         if (i_redirect) begin
            m_pc = {i_redirect_pc[31:2], 2'b00}; m_instr = 0; m_valid = 0;
         end else if (go && !i_stall && i_flush) begin
            m_pc = m_pc + 4; m_instr = 0; m_valid = 0;
         end else if (go && !i_stall) begin
            word = m_mem[m_pc[NB_ADDR+1:2]];
            m_instr = word; m_opc = m_pc; m_opc4 = m_pc + 4; m_valid = 1;
            if (word == HALT) m_phase = 2;
            else m_pc = m_pc + 4;
         end
      end else begin
         m_instr = 0; m_valid = 0;
      end
      @(posedge i_clock);
      #1;
   endtask

   task automatic clear_inputs();
      i_reset = 0; i_start = 0; i_stall = 0; i_flush = 0; i_redirect = 0;
      i_redirect_pc = 0; i_step = 1; i_imem_we = 0; i_imem_waddr = 0; i_imem_wdata = 0;
   endtask

   task automatic do_reset();
      i_reset = 1;
      tick();
      i_reset = 0;
   endtask

   task automatic write_word(input int addr, input logic [31:0] data);
      i_imem_we = 1; i_imem_waddr = NB_ADDR'(addr); i_imem_wdata = data;
      tick();
      i_imem_we = 0;
   endtask

   task automatic start_run();
      i_start = 1;
      tick();
      i_start = 0;
   endtask

   task automatic load_all();
      for (int a = 0; a < DEPTH; a++) write_word(a, rnd_word());
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (o_instruction !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h expected 0", o_instruction); end
      total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
      total++; if (o_pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc4: got %h expected 4", o_pc_plus4); end
      total++; if ({o_valid, o_halted} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b expected 00", {o_valid, o_halted}); end
      total++; if (o_cycle_count !== 32'h0) begin bad++; $display("FAIL reset_count: got %0d expected 0", o_cycle_count); end
   endtask

   task automatic test_program_halt();
      do_reset();
      write_word(0, 32'h2001_0005);
      write_word(1, 32'h2002_0007);
      write_word(2, HALT);
      start_run();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL prog_first_run_cycle: valid=%b expected 0", o_valid); end
      for (int i = 0; i < 8; i++) begin
         tick();
         total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL prog_model_%0d: got %h expected %h", i, dut_vec, exp_vec()); end
         if (i == 0) begin
            total++; if ({o_instruction, o_pc, o_valid} !== {32'h2001_0005, 32'h0, 1'b1}) begin bad++; $display("FAIL prog_pc0: got %h/%h/%b", o_instruction, o_pc, o_valid); end
         end else if (i == 1) begin
            total++; if ({o_instruction, o_pc, o_valid} !== {32'h2002_0007, 32'h4, 1'b1}) begin bad++; $display("FAIL prog_pc4: got %h/%h/%b", o_instruction, o_pc, o_valid); end
         end else if (i == 2) begin
            total++; if ({o_instruction, o_pc, o_valid, o_halted} !== {HALT, 32'h8, 2'b11}) begin bad++; $display("FAIL prog_halt: got %h/%h/%b/%b", o_instruction, o_pc, o_valid, o_halted); end
         end else begin
            total++; if ({o_valid, o_halted, o_cycle_count} !== {2'b01, 32'd3}) begin bad++; $display("FAIL prog_after_halt_%0d: got %b/%b/%0d expected 0/1/3", i, o_valid, o_halted, o_cycle_count); end
         end
      end
      do_reset();
      write_word(2, rnd_word());
   endtask

   task automatic test_stall_redirect();
      do_reset();
      start_run();
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL run_model_%0d: got %h expected %h", i, dut_vec, exp_vec()); end
      end
      i_stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL stall_model_%0d: got %h expected %h", i, dut_vec, exp_vec()); end
         total++; if ({o_pc, o_valid, o_instruction} !== {32'h8, 1'b1, m_mem[2]}) begin bad++; $display("FAIL stall_hold_%0d: got %h/%b/%h", i, o_pc, o_valid, o_instruction); end
      end
      i_stall = 0;
      tick();
      total++; if ({o_pc, o_valid, o_instruction} !== {32'hC, 1'b1, m_mem[3]}) begin bad++; $display("FAIL stall_resume: got %h/%b/%h expected c/1/%h", o_pc, o_valid, o_instruction, m_mem[3]); end
      i_redirect = 1; i_redirect_pc = 32'h0000_0013;
      tick();
      i_redirect = 0;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL redirect_bubble: valid=%b expected 0", o_valid); end
      tick();
      total++; if ({o_pc, o_valid, o_instruction} !== {32'h10, 1'b1, m_mem[4]}) begin bad++; $display("FAIL redirect_target: got %h/%b/%h expected 10/1/%h", o_pc, o_valid, o_instruction, m_mem[4]); end
      i_redirect = 1; i_stall = 1; i_redirect_pc = 32'h0000_0020;
      tick();
      i_redirect = 0; i_stall = 0;
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL redir_stall_model: got %h expected %h", dut_vec, exp_vec()); end
      tick();
      total++; if ({o_pc, o_valid, o_instruction} !== {32'h20, 1'b1, m_mem[8]}) begin bad++; $display("FAIL redir_over_stall: got %h/%b/%h expected 20/1/%h", o_pc, o_valid, o_instruction, m_mem[8]); end
   endtask

   task automatic test_flush_halt();
      do_reset();
      write_word(1, HALT);
      start_run();
      tick();
      i_flush = 1;
      tick();
      i_flush = 0;
      total++; if ({o_valid, o_halted} !== 2'b00) begin bad++; $display("FAIL flush_halt_bubble: got %b expected 00", {o_valid, o_halted}); end
      tick();
      total++; if ({o_pc, o_valid, o_halted, o_instruction} !== {32'h8, 2'b10, m_mem[2]}) begin bad++; $display("FAIL flush_halt_continue: got %h/%b/%b/%h", o_pc, o_valid, o_halted, o_instruction); end
      total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL flush_halt_model: got %h expected %h", dut_vec, exp_vec()); end
      do_reset();
      write_word(1, rnd_word());
   endtask

   task automatic test_imem_write_in_run();
      do_reset();
      start_run();
      tick();
      i_imem_we = 1; i_imem_waddr = 2; i_imem_wdata = HALT;
      tick();
      i_imem_we = 0;
      tick();
      total++; if ({o_pc, o_halted, o_instruction} !== {32'h8, 1'b0, m_mem[2]}) begin bad++; $display("FAIL run_write_ignored: got %h/%b/%h expected 8/0/%h", o_pc, o_halted, o_instruction, m_mem[2]); end
   endtask

   task automatic test_random();
      do_reset();
      start_run();
      for (int i = 0; i < 400; i++) begin
         i_redirect    = ($urandom_range(0, 99) < 8);
         i_stall       = ($urandom_range(0, 99) < 20);
         i_flush       = ($urandom_range(0, 99) < 10);
         i_redirect_pc = 32'($urandom_range(0, 255));
         i_step        = ($urandom_range(0, 99) < 70);
         i_start       = ($urandom_range(0, 99) < 5);
         i_imem_we     = ($urandom_range(0, 99) < 10);
         i_imem_waddr  = NB_ADDR'($urandom_range(0, 63));
         i_imem_wdata  = ($urandom_range(0, 1) == 1) ? HALT : 32'($urandom);
         tick();
         total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec()); end
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      start_run();
      for (int i = 0; i < 5; i++) tick();
      i_reset = 1;
      tick();
      i_reset = 0;
      total++; if (dut_vec !== {32'h0, 32'h0, 32'h4, 2'b00, 32'h0}) begin bad++; $display("FAIL mid_run_reset: got %h", dut_vec); end
      tick();
      total++; if ({o_valid, o_cycle_count} !== {1'b0, 32'h0}) begin bad++; $display("FAIL mid_run_reset_idle: got %b/%0d expected 0/0", o_valid, o_cycle_count); end
   endtask

   task automatic test_step();
      int steps;
      steps = 0;
      do_reset();
      start_run();
      for (int i = 0; i < 20; i++) begin
`ifdef STEP_MODE_EN
         i_step = (i % 2 == 1);
`else
         i_step = $urandom_range(0, 1) == 1;
`endif
         if (i_step) steps++;
         tick();
         total++; if (dut_vec !== exp_vec()) begin bad++; $display("FAIL step_model_%0d: got %h expected %h", i, dut_vec, exp_vec()); end
      end
      i_step = 1;
`ifdef STEP_MODE_EN
      total++; if ({o_cycle_count, o_pc} !== {32'(steps), 32'((steps - 1) * 4)}) begin bad++; $display("FAIL step_count: got %0d/%h expected %0d/%h", o_cycle_count, o_pc, steps, (steps - 1) * 4); end
`else
      total++; if ({o_cycle_count, o_pc} !== {32'd20, 32'd76}) begin bad++; $display("FAIL step_ignored: got %0d/%h expected 20/4c", o_cycle_count, o_pc); end
`endif
   endtask

   // Scenario sequence
   initial begin
      clear_inputs();
      do_reset();
      test_reset();
      load_all();
      test_program_halt();
      test_stall_redirect();
      test_flush_halt();
      test_imem_write_in_run();
      test_random();
      test_reset_mid_run();
      test_step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage with integrated IF/ID pipeline register. Holds the PC and a word-addressed instruction memory, loaded over a write port before execution starts. Each cycle it presents one instruction plus `valid` to the decode stage's control unit (`i_instruction`, `i_valid`). It honours stall, flush and redirect requests from decode/execute, and stops fetching when it latches the halt word.

## Interface
Parameters:
- `NB_DATA`, 32, instruction/PC width
- `NB_ADDR`, 10, imem word-address width (2^NB_ADDR words)
- `HALT_WORD`, 32'hFFFF_FFFF, instruction that ends execution

Ports:
- `i_clock`  in  1  clock; all state updates on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_start`  in  1  leave IDLE and begin fetching at PC 0
- `i_stall`  in  1  hold PC and IF/ID contents
- `i_flush`  in  1  load bubble into IF/ID; PC advances normally
- `i_redirect`  in  1  load PC from `i_redirect_pc`; bubble into IF/ID
- `i_redirect_pc`  in  NB_DATA  redirect target (byte address)
- `i_step`  in  1  single-step advance; used only with STEP_MODE_EN
- `i_imem_we`  in  1  imem write enable (IDLE only)
- `i_imem_waddr`  in  NB_ADDR  imem word address
- `i_imem_wdata`  in  NB_DATA  imem write data
- `o_instruction`  out  NB_DATA  IF/ID instruction
- `o_pc`  out  NB_DATA  byte address of `o_instruction`
- `o_pc_plus4`  out  NB_DATA  `o_pc + 4`
- `o_valid`  out  1  IF/ID holds a real instruction
- `o_halted`  out  1  state is HALTED
- `o_cycle_count`  out  NB_DATA  cycles spent in RUN

## Operation
- States: IDLE, RUN, HALTED.
  - IDLE → RUN on `i_start`.
  - RUN → HALTED when `HALT_WORD` is latched into IF/ID.
  - HALTED → IDLE only via reset.
- Reset values: state IDLE, PC 0, `o_instruction` 0, `o_pc` 0, `o_pc_plus4` 4, `o_valid` 0, `o_halted` 0, `o_cycle_count` 0. Imem contents are not reset.
- Imem writes:
  - Accepted only in IDLE; ignored in RUN/HALTED.
  - Imem read is combinational at `PC[NB_ADDR+1:2]`. Upper PC bits are ignored, so addresses wrap.
- RUN per-cycle priority (highest first):
  1. `i_redirect`: PC ← `{i_redirect_pc[NB_DATA-1:2], 2'b00}`; IF/ID ← bubble.
  2. `i_stall`: PC and IF/ID hold.
  3. `i_flush`: PC ← PC+4; IF/ID ← bubble.
  4. Normal: IF/ID ← {imem[PC], PC, PC+4, valid=1}; PC ← PC+4.
- Bubble: instruction 0, valid 0; `o_pc`/`o_pc_plus4` hold their previous values.
- Halt detection:
  - Applies only on the normal path. A halt word under redirect, stall or flush is not latched and does not halt.
  - The halt word itself is presented with `o_valid`=1 for one cycle.
  - On every later cycle IF/ID shows a bubble and PC is frozen.
- In IDLE and HALTED: PC frozen; `i_stall`/`i_flush`/`i_redirect` ignored; IF/ID holds a bubble.
- `o_cycle_count` increments every cycle in RUN, stalls included, and wraps at 2^NB_DATA. It freezes in HALTED.
- PC+4 wraps modulo 2^NB_DATA.

## Timing
- `i_start` at cycle t: first instruction (PC 0) on IF/ID outputs at t+2. Cycle t+1 is the first RUN cycle.
- Redirect at cycle t: `o_valid`=0 at t+1; target instruction on outputs at t+2.
- Stall is zero-latency: outputs at t+1 equal outputs at t.
- `o_halted` asserts in the same cycle the halt word appears on `o_instruction`.
- Reset asserted mid-RUN: every output takes its reset value on the next edge; in-flight state is lost.

## Configuration
- `STEP_MODE_EN` defined:
  - In RUN, a cycle with `i_step`=0 behaves exactly as `i_stall`=1.
  - With `i_step`=1 the normal priority applies.
  - `o_cycle_count` counts only stepped cycles.
- Not defined: `i_step` is ignored and the stage free-runs.

## Structure
- Shared package holds:
  - state encoding (IDLE/RUN/HALTED)
  - `HALT_WORD` default
  - NOP/bubble constant (32'h0)
  - PC increment constant 4
- Sub-module `instruction_memory`: 2^NB_ADDR×NB_DATA array, one synchronous write port, one combinational read port. The fetch FSM, PC and IF/ID register stay in the top module.

## Test plan
- Load imem[0..2] = 0x20010005, 0x20020007, 0xFFFFFFFF; pulse `i_start` → valid instructions at PCs 0, 4, 8 on consecutive cycles; `o_halted`=1 with PC 8; `o_valid`=0 on every later cycle; `o_cycle_count` freezes.
- Mid-RUN `i_stall` for 3 cycles → outputs unchanged for 3 cycles; sequence resumes at the next PC with no skipped or duplicated instruction.
- `i_redirect`=1, `i_redirect_pc`=0x0000_0013 → one bubble, then the instruction from byte address 0x10.
- `i_redirect` and `i_stall` in the same cycle → redirect wins; PC = target.
- Halt word at PC 4 coincident with `i_flush` → no halt; fetch continues at PC 8.
- With `STEP_MODE_EN`, toggle `i_step` every other cycle → one instruction per step; `o_cycle_count` equals the step count. Also check: an imem write during RUN is ignored, and reset mid-RUN returns all outputs to their reset values.
